llr_packer: RTL
===============

LLR_PACKER -- requirements
Module: llr_packer

Interface
REQ-001 Parameter LLR_W, 5, width of one soft-bit LLR word.
REQ-002 Parameter GROUP, 8, LLR words per output vector; power of two, 2..64.
REQ-003 Parameter PAD_VAL, '0, LLR value written to unfilled lanes on a short-group flush (erasure).
REQ-004 Port clk_h  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port ival  input  1  input word valid.
REQ-007 Port iready  output  1  input can be accepted; a word is accepted when ival && iready.
REQ-008 Port isop / ieop / ieof  input  1 each  start of packet / end of packet / end of frame, qualified by accepted word.
REQ-009 Port ibit  input  LLR_W  input LLR word.
REQ-010 Port oval  output  1  output vector valid.
REQ-011 Port oready  input  1  downstream accepts; a vector is consumed when oval && oready.
REQ-012 Port osop / oeop / oeof  output  1 each  packet/frame flags of the output vector.
REQ-013 Port obit  output  LLR_W x [0:GROUP-1]  packed vector; lane 0 = earliest accepted word.
REQ-014 Port olanes  output  $clog2(GROUP)+1  count of real (non-pad) lanes, 1..GROUP.
REQ-015 Port oerr  output  1  one-cycle pulse on protocol error.

Function
REQ-016 Accumulator SHALL store accepted words at index cnt, cnt incrementing per accepted word, wrapping to 0 on group close.
REQ-017 Group closes on accepted word when cnt==GROUP-1 or ieop==1 (whichever first); closing word included.
REQ-018 On close, if output register free (!oval || oready same cycle), vector SHALL load into output register that edge: oval high next cycle (latency 1 from closing word).
REQ-019 If output register not free on close, group SHALL be held (state HOLD) and iready deasserted; held group loads on first cycle output frees; iready returns high the cycle after load.
REQ-020 States: FILL (iready=1), HOLD (iready=0); FILL->HOLD on close with output busy; HOLD->FILL on load. iready SHALL be combinational from state only, never from oready.
REQ-021 Sustained ival=1, oready=1 SHALL give one accepted word per cycle, no bubbles.
REQ-022 Short group (ieop before GROUP words): lanes cnt+1..GROUP-1 SHALL equal PAD_VAL; olanes = words received.
REQ-023 Full group: olanes = GROUP.
REQ-024 osop = isop of lane-0 word; oeop = ieop of closing word; oeof = ieof of closing word if ieop also set, else 0.
REQ-025 isop/ieof on non-qualifying words SHALL be ignored (no error).
REQ-026 isop on word with cnt!=0: partial group discarded, oerr pulses one cycle, word taken as lane 0 of new group.
REQ-027 isop and ieop on same word: single-lane group, osop=oeop=1, olanes=1.
REQ-028 oval, obit, flags, olanes SHALL hold stable while oval && !oready.
REQ-029 On consumption with no new load, oval and all flags SHALL drop to 0 next cycle; obit/olanes SHALL zero.
REQ-030 Input words with ival=0 SHALL not change cnt or accumulator.

Reset
REQ-031 rst_n low SHALL asynchronously clear: cnt=0, state FILL, accumulator, oval, osop, oeop, oeof, oerr, obit, olanes to 0.
REQ-032 Reset mid-group or in HOLD SHALL discard all buffered data; no partial vector emitted after release.
REQ-033 iready SHALL read 1 during and immediately after reset.

Verification
REQ-034 GROUP=8, 16 words 0..15 continuous, isop on word 0, ieop on 15, oready=1 -> two vectors: {0..7} osop=1 olanes=8, {8..15} oeop=1 olanes=8, each 1 cycle after closing word; iready never low.
REQ-035 5 words 1..5, isop on 1, ieop+ieof on 5 -> one vector lanes 0..4=1..5, lanes 5..7=PAD_VAL, olanes=5, osop=oeop=oeof=1.
REQ-036 oready=0 for 20 cycles during 16-word stream -> first vector held stable, second group enters HOLD, iready=0 after word 15; oready=1 -> both vectors in order, no loss.
REQ-037 isop on word index 3 of a group -> oerr pulse 1 cycle, next vector lane 0 = that word, osop=1.
REQ-038 rst_n asserted in HOLD with oval=1 -> all outputs 0 asynchronously; after release, 8 new words produce exactly one vector of only the new data.

Source files
------------

// File: rtl/llr_packer.sv
// llr_packer: gathers LLR_W-bit soft-bit words into GROUP-lane vectors.
//   clk_h, rst_n         : clock (rising edge) and async active-low reset
//   ival/iready          : input handshake, word accepted when both high
//   isop/ieop/ieof, ibit : input flags and LLR word
//   oval/oready          : output handshake, vector consumed when both high
//   osop/oeop/oeof       : flags of the presented vector
//   obit                 : packed vector, lane 0 = earliest word
//   olanes               : number of real (non-pad) lanes
//   oerr                 : one-cycle pulse when isop arrives mid-group
module llr_packer #(
  parameter int unsigned      LLR_W   = 5,
  parameter int unsigned      GROUP   = 8,
  parameter logic [LLR_W-1:0] PAD_VAL = '0
) (
  input  logic                            clk_h,
  input  logic                            rst_n,
  input  logic                            ival,
  output logic                            iready,
  input  logic                            isop,
  input  logic                            ieop,
  input  logic                            ieof,
  input  logic [LLR_W-1:0]                ibit,
  output logic                            oval,
  input  logic                            oready,
  output logic                            osop,
  output logic                            oeop,
  output logic                            oeof,
  output logic [GROUP-1:0][LLR_W-1:0]     obit,
  output logic [$clog2(GROUP):0]          olanes,
  output logic                            oerr
);

  localparam int unsigned CNT_W  = $clog2(GROUP);
  localparam int unsigned LANE_W = CNT_W + 1;

  typedef logic [GROUP-1:0][LLR_W-1:0] vec_t;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  vec_t               acc_q;
  logic               grp_sop_q;
  logic               h_sop_q, h_eop_q, h_eof_q;
  logic [LANE_W-1:0]  h_lanes_q;

  logic               out_free_c, accept_c, restart_c, close_c;
  logic               load_new_c, load_held_c, sop_c;
  logic [CNT_W-1:0]   idx_c;
  logic [LANE_W-1:0]  lanes_c;
  vec_t               vec_c;

  // Input side is open only while no closed group is parked.
  assign iready = (state_q == FILL);

  // Next-state and group-assembly decode.
  always_comb begin
    state_d     = state_q;
    out_free_c  = !oval || oready;
    accept_c    = ival && (state_q == FILL);
    // isop mid-group drops the partial group and restarts at lane 0.
    restart_c   = accept_c && isop && (cnt_q != '0);
    idx_c       = restart_c ? '0 : cnt_q;
    close_c     = accept_c && ((idx_c == CNT_W'(GROUP - 1)) || ieop);
    sop_c       = (idx_c == '0) ? isop : grp_sop_q;
    lanes_c     = LANE_W'(idx_c) + LANE_W'(1);
    load_new_c  = close_c && out_free_c;
    load_held_c = (state_q == HOLD) && out_free_c;
    vec_c       = '0;
    // Closing word lands at idx_c; lanes beyond it are erasures.
    for (int i = 0; i < int'(GROUP); i++) begin
      if (CNT_W'(i) < idx_c)       vec_c[i] = acc_q[i];
      else if (CNT_W'(i) == idx_c) vec_c[i] = ibit;
      else                         vec_c[i] = PAD_VAL;
    end
    case (state_q)
      FILL:    if (close_c && !out_free_c) state_d = HOLD;
      HOLD:    if (out_free_c)             state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Accumulator, parked group and output register.
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      grp_sop_q <= 1'b0;
      h_sop_q   <= 1'b0;
      h_eop_q   <= 1'b0;
      h_eof_q   <= 1'b0;
      h_lanes_q <= '0;
      oval      <= 1'b0;
      osop      <= 1'b0;
      oeop      <= 1'b0;
      oeof      <= 1'b0;
      obit      <= '0;
      olanes    <= '0;
      oerr      <= 1'b0;
    end else begin
      oerr <= restart_c;

      if (accept_c) begin
        if (close_c) begin
          cnt_q <= '0;
        end else begin
          cnt_q        <= idx_c + CNT_W'(1);
          acc_q[idx_c] <= ibit;
        end
        if (idx_c == '0) grp_sop_q <= isop;
      end

      // Output busy at close: park the finished vector in the accumulator.
      if (close_c && !out_free_c) begin
        acc_q     <= vec_c;
        h_sop_q   <= sop_c;
        h_eop_q   <= ieop;
        h_eof_q   <= ieop && ieof;
        h_lanes_q <= lanes_c;
      end

      if (load_new_c) begin
        oval   <= 1'b1;
        obit   <= vec_c;
        osop   <= sop_c;
        oeop   <= ieop;
        oeof   <= ieop && ieof;
        olanes <= lanes_c;
      end else if (load_held_c) begin
        oval   <= 1'b1;
        obit   <= acc_q;
        osop   <= h_sop_q;
        oeop   <= h_eop_q;
        oeof   <= h_eof_q;
        olanes <= h_lanes_q;
      end else if (oval && oready) begin
        oval   <= 1'b0;
        obit   <= '0;
        osop   <= 1'b0;
        oeop   <= 1'b0;
        oeof   <= 1'b0;
        olanes <= '0;
      end
    end
  end

endmodule
